// File: rtl/iterative_slice_adder_pkg.sv
// Shared types and helpers for the iterative slice adder.
// The state enum and the slice-counter width function live here.
package isa_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // Width of the slice counter; never below one bit, even for a single slice.
  function automatic int unsigned cnt_width(input int unsigned n, input int unsigned w);
    int unsigned slices;
    slices = n / w;
    return (slices > 1) ? $clog2(slices) : 1;
  endfunction

endpackage

// File: rtl/iterative_slice_adder_if.sv
// Request/result bundle of the iterative slice adder.
// The master side issues operands and start; the slave side returns the result.
interface iterative_slice_adder_if #(
  parameter int unsigned N = 8
);
  logic         start;
  logic         sub;
  logic         cin;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] s;
  logic         carry_out;
  logic         overflow;

  modport master (
    output start, sub, cin, a, b,
    input  busy, done, s, carry_out, overflow
  );

  modport slave (
    input  start, sub, cin, a, b,
    output busy, done, s, carry_out, overflow
  );
endinterface

// File: rtl/iterative_slice_adder_w_slice.sv
// Purely combinational W-bit adder with carry in and carry out.
// The iterative top reuses one instance for every slice.
module w_slice_adder #(
  parameter int unsigned W = 2
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/iterative_slice_adder.sv
// N-bit add/subtract unit that reuses one W-bit slice adder over N/W cycles,
// least-significant slice first, with the inter-slice carry held in a register.
module iterative_slice_adder
  import isa_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned W = 2
) (
  input logic                   clk,
  input logic                   reset,
  iterative_slice_adder_if.slave bus
);

  localparam int unsigned     Slices    = N / W;
  localparam int unsigned     CntW      = cnt_width(N, W);
  localparam logic [CntW-1:0] LastSlice = CntW'(Slices - 1);

  if (W == 0 || W > N || (N % W) != 0) begin : g_param_check
    $error("iterative_slice_adder: N (%0d) must be a nonzero multiple of W (%0d)", N, W);
  end

  state_e          state_q, state_d;
  logic [N-1:0]    op_a_q, op_a_d;
  logic [N-1:0]    op_b_q, op_b_d;
  logic [N-1:0]    s_q, s_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [W-1:0]    slice_a, slice_b, slice_sum;
  logic            slice_cout;

  assign slice_a = op_a_q[cnt_q*W +: W];
  assign slice_b = op_b_q[cnt_q*W +: W];

  w_slice_adder #(
    .W(W)
  ) u_slice (
    .a   (slice_a),
    .b   (slice_b),
    .cin (carry_q),
    .sum (slice_sum),
    .cout(slice_cout)
  );

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    s_d     = s_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_a_d  = bus.a;
          // Subtraction is a + ~b + 1; the +1 enters as the initial carry.
          op_b_d  = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub | bus.cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        s_d[cnt_q*W +: W] = slice_sum;
        carry_d           = slice_cout;
        cnt_d             = cnt_q + 1'b1;
        if (cnt_q == LastSlice) begin
          cout_d  = slice_cout;
          ovf_d   = (op_a_q[N-1] == op_b_q[N-1]) && (slice_sum[W-1] != op_a_q[N-1]);
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.busy      = (state_q == RUN);
  assign bus.done      = (state_q == DONE);
  assign bus.s         = s_q;
  assign bus.carry_out = cout_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_iterative_slice_adder.sv
// Bench for iterative_slice_adder: three configurations (8/2, 16/4, 8/1) run in lockstep
// against a signed/unsigned arithmetic reference model.
module tb_iterative_slice_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  iterative_slice_adder_if #(.N(8))  bus0 ();
  iterative_slice_adder_if #(.N(16)) bus1 ();
  iterative_slice_adder_if #(.N(8))  bus2 ();

  iterative_slice_adder #(.N(8),  .W(2)) u_dut0 (.clk(clk), .reset(rst_n), .bus(bus0));
  iterative_slice_adder #(.N(16), .W(4)) u_dut1 (.clk(clk), .reset(rst_n), .bus(bus1));
  iterative_slice_adder #(.N(8),  .W(1)) u_dut2 (.clk(clk), .reset(rst_n), .bus(bus2));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        sub;
    logic        cin;
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  s;
    logic        c;
    logic        v;
  } vec_t;

  function automatic int n_of(input int d);
    return (d == 1) ? 16 : 8;
  endfunction

  function automatic int slices_of(input int d);
    return (d == 2) ? 8 : 4;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference: plain modular arithmetic plus signed range test.
  function automatic void model(input int n, input logic sb, input logic ci,
                                input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] s, output logic c, output logic v);
    longint mask, ua, ub, sa, sbv, full, res, lim;
    mask = (longint'(1) << n) - 1;
    lim  = longint'(1) << (n - 1);
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    sa   = (ua >= lim) ? ua - (mask + 1) : ua;
    sbv  = (ub >= lim) ? ub - (mask + 1) : ub;
    if (sb) begin
      full = ua - ub;
      c    = (ua >= ub);
      res  = sa - sbv;
    end else begin
      full = ua + ub + longint'(ci);
      c    = (full > mask);
      res  = sa + sbv + longint'(ci);
    end
    s = 16'(full & mask);
    v = (res >= lim) || (res < -lim);
  endfunction

  task automatic drive(input logic st, input logic sb, input logic ci,
                       input logic [15:0] a, input logic [15:0] b);
    bus0.start = st; bus1.start = st; bus2.start = st;
    bus0.sub   = sb; bus1.sub   = sb; bus2.sub   = sb;
    bus0.cin   = ci; bus1.cin   = ci; bus2.cin   = ci;
    bus0.a = a[7:0]; bus1.a = a; bus2.a = a[7:0];
    bus0.b = b[7:0]; bus1.b = b; bus2.b = b[7:0];
  endtask

  task automatic get_out(input int d, output logic [15:0] s, output logic busy,
                         output logic done, output logic co, output logic ov);
    case (d)
      0: begin s = {8'h0, bus0.s}; busy = bus0.busy; done = bus0.done;
               co = bus0.carry_out; ov = bus0.overflow; end
      1: begin s = bus1.s; busy = bus1.busy; done = bus1.done;
               co = bus1.carry_out; ov = bus1.overflow; end
      default: begin s = {8'h0, bus2.s}; busy = bus2.busy; done = bus2.done;
               co = bus2.carry_out; ov = bus2.overflow; end
    endcase
  endtask

  // One operation on all three DUTs over a fixed 12-edge window.
  // disturb: change operands after capture and re-pulse start during RUN.
  task automatic run_op(input string name, input logic sb, input logic ci,
                        input logic [15:0] a, input logic [15:0] b, input bit disturb,
                        input bit has_exp, input logic [7:0] xs, input logic xc,
                        input logic xv);
    logic [15:0] es[3], rs[3], hs[3];
    logic        ec[3], ev[3], rc[3], rv[3];
    int          first[3], dones[3], busys[3];
    logic [15:0] os;
    logic        ob, od, oc, ov;
    for (int d = 0; d < 3; d++) begin
      model(n_of(d), sb, ci, a, b, es[d], ec[d], ev[d]);
      first[d] = -1; dones[d] = 0; busys[d] = 0;
      rs[d] = '0; rc[d] = 1'b0; rv[d] = 1'b0;
    end
    if (has_exp) begin
      es[0] = {8'h0, xs}; ec[0] = xc; ev[0] = xv;
    end
    drive(1'b1, sb, ci, a, b);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        if (disturb) drive(1'b0, ~sb, ~ci, ~a, 16'h0055);
        else drive(1'b0, sb, ci, a, b);
      end
      if (disturb && k == 2) drive(1'b1, sb, ci, 16'h0055, 16'h00aa);
      if (disturb && k == 3) drive(1'b0, sb, ci, 16'h0055, 16'h00aa);
      for (int d = 0; d < 3; d++) begin
        get_out(d, os, ob, od, oc, ov);
        if (ob) busys[d]++;
        if (od) begin
          dones[d]++;
          if (first[d] < 0) begin
            first[d] = k; rs[d] = os; rc[d] = oc; rv[d] = ov;
          end
        end
        if (k == 12) hs[d] = os;
      end
    end
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s/dut%0d/latency", name, d), first[d], slices_of(d) + 1);
      check($sformatf("%s/dut%0d/done_pulses", name, d), dones[d], 1);
      check($sformatf("%s/dut%0d/busy_cycles", name, d), busys[d], slices_of(d));
      check($sformatf("%s/dut%0d/s", name, d), rs[d], es[d]);
      check($sformatf("%s/dut%0d/carry_out", name, d), rc[d], ec[d]);
      check($sformatf("%s/dut%0d/overflow", name, d), rv[d], ev[d]);
      check($sformatf("%s/dut%0d/s_hold", name, d), hs[d], es[d]);
    end
  endtask

  task automatic check_zero(input string name);
    logic [15:0] os;
    logic        ob, od, oc, ov;
    for (int d = 0; d < 3; d++) begin
      get_out(d, os, ob, od, oc, ov);
      check($sformatf("%s/dut%0d/s", name, d), os, 0);
      check($sformatf("%s/dut%0d/busy", name, d), ob, 0);
      check($sformatf("%s/dut%0d/done", name, d), od, 0);
      check($sformatf("%s/dut%0d/carry_out", name, d), oc, 0);
      check($sformatf("%s/dut%0d/overflow", name, d), ov, 0);
    end
  endtask

  initial begin
    vec_t        tbl[10];
    logic [15:0] corner[5];
    logic [15:0] os;
    logic        ob, od, oc, ov;
    int          stray;

    tbl[0] = '{sub: 1'b0, cin: 1'b0, a: 16'h00ff, b: 16'h0001, s: 8'h00, c: 1'b1, v: 1'b0};
    tbl[1] = '{sub: 1'b0, cin: 1'b0, a: 16'h007f, b: 16'h0001, s: 8'h80, c: 1'b0, v: 1'b1};
    tbl[2] = '{sub: 1'b0, cin: 1'b1, a: 16'h0010, b: 16'h0020, s: 8'h31, c: 1'b0, v: 1'b0};
    tbl[3] = '{sub: 1'b1, cin: 1'b0, a: 16'h0005, b: 16'h0007, s: 8'hfe, c: 1'b0, v: 1'b0};
    tbl[4] = '{sub: 1'b1, cin: 1'b0, a: 16'h0080, b: 16'h0001, s: 8'h7f, c: 1'b1, v: 1'b1};
    tbl[5] = '{sub: 1'b1, cin: 1'b1, a: 16'h0005, b: 16'h0007, s: 8'hfe, c: 1'b0, v: 1'b0};
    tbl[6] = '{sub: 1'b0, cin: 1'b1, a: 16'h00ff, b: 16'h00ff, s: 8'hff, c: 1'b1, v: 1'b0};
    tbl[7] = '{sub: 1'b1, cin: 1'b0, a: 16'h0000, b: 16'h0000, s: 8'h00, c: 1'b1, v: 1'b0};
    tbl[8] = '{sub: 1'b0, cin: 1'b0, a: 16'h0080, b: 16'h0080, s: 8'h00, c: 1'b1, v: 1'b1};
    tbl[9] = '{sub: 1'b1, cin: 1'b0, a: 16'h0000, b: 16'h0080, s: 8'h80, c: 1'b0, v: 1'b1};
    corner[0] = 16'h0000; corner[1] = 16'h0001; corner[2] = 16'h007f;
    corner[3] = 16'h0080; corner[4] = 16'hffff;

    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    #12;
    check_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("tbl%0d", i), tbl[i].sub, tbl[i].cin, tbl[i].a, tbl[i].b, 1'b0,
             1'b1, tbl[i].s, tbl[i].c, tbl[i].v);
    end

    // Operands changed after capture and start re-pulsed during RUN.
    run_op("handshake_add", 1'b0, 1'b0, 16'h3c3c, 16'h1a1a, 1'b1, 1'b0, 8'h0, 1'b0, 1'b0);
    run_op("handshake_sub", 1'b1, 1'b0, 16'h1234, 16'hf00d, 1'b1, 1'b0, 8'h0, 1'b0, 1'b0);

    // Reset in the second RUN cycle aborts with no done.
    drive(1'b1, 1'b0, 1'b1, 16'h1234, 16'h0f0f);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b1, 16'h1234, 16'h0f0f);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("midop_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    stray = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
        get_out(d, os, ob, od, oc, ov);
        if (od || ob) stray++;
      end
    end
    check("midop_reset/no_done_after", stray, 0);
    run_op("after_reset", 1'b0, 1'b0, 16'h00ff, 16'h0001, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);

    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        for (int m = 0; m < 2; m++) begin
          run_op($sformatf("corner_%0h_%0h_%0d", corner[i], corner[j], m), m[0], 1'b0,
                 corner[i], corner[j], 1'b0, 1'b0, 8'h0, 1'b0, 1'b0);
        end
      end
    end

    for (int i = 0; i < 1500; i++) begin
      run_op($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             16'($urandom), 16'($urandom), ($urandom_range(0, 7) == 0), 1'b0, 8'h0, 1'b0,
             1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iterative_slice_adder.md
Name: iterative_slice_adder

Overview:
Parametrised N-bit add/subtract unit built as iterative logic. A single W-bit slice adder is reused over N/W clock cycles, from the least-significant slice upward, with the carry held in a register between slices. It is the sequential, area-reduced successor to the combinational N-bit adder built from narrow slices. It adds a subtract mode, carry-in, signed-overflow detection and a start/done handshake.

Parameters:
N, 8, operand/result width in bits; N % W == 0 required (elaboration-time $error otherwise)
W, 2, slice width in bits processed per cycle; 1 <= W <= N

Ports:
clk  input  1  single clock; all state changes on its rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  request; sampled only in IDLE
sub  input  1  0 = a+b+cin, 1 = a-b (cin ignored)
cin  input  1  carry-in for add mode
a  input  N  operand A, captured on accepted start
b  input  N  operand B, captured on accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse: result valid
s  output  N  sum/difference
carry_out  output  1  carry out of bit N-1 (sub: 1 = no borrow)
overflow  output  1  signed two's-complement overflow

Behaviour:
- States: IDLE, RUN, DONE. Reset (reset=0, async) -> IDLE; s, carry_out, overflow, busy, done = 0; slice counter = 0; carry register = 0.
- IDLE with start=1 at an edge:
  - Capture a into op_a.
  - Capture b into op_b; in sub mode b is inverted (~b).
  - Carry register <= (sub ? 1 : cin).
  - Counter <= 0; go to RUN. Operand/mode changes after capture have no effect.
- RUN, at each edge, for slice k = counter:
  - {c, r} = op_a[k*W +: W] + op_b[k*W +: W] + carry.
  - s[k*W +: W] <= r; carry <= c; counter++.
  - On the last slice (k = N/W-1):
    - carry_out <= c.
    - overflow <= (op_a[N-1] == op_b[N-1]) && (r[W-1] != op_a[N-1]).
    - Go to DONE.
- DONE: done=1 for exactly one cycle, busy=0; next edge -> IDLE.
- Latency: start sampled at edge t0; slices at edges t1..t(N/W); done high in the cycle after edge t(N/W). Default N=8, W=2 gives 4 RUN cycles; done visible 5 edges after start.
- s, carry_out and overflow hold their values from DONE until the next accepted start. During RUN, s is partially updated and is not valid until done.
- busy = (state == RUN). start is ignored in RUN and DONE; it is not queued.
- W == N: one RUN cycle. W == 1: N RUN cycles (bit-serial).
- Reset asserted mid-RUN aborts immediately; all outputs return to 0, and no done is produced for the aborted operation.
- Arithmetic is modulo 2^N; no saturation.

Decomposition:
- Package isa_pkg:
  - state typedef enum logic [1:0] {IDLE, RUN, DONE}.
  - Counter-width function clog2-based: CNT_W = max(1, $clog2(N/W)).
- Sub-module w_slice_adder #(W): purely combinational W-bit adder with cin/cout, instantiated once. The FSM, operand registers, counter and carry register live in the top module.

Test Plan:
- Add, N=8 W=2: a=0xFF, b=0x01, cin=0 -> s=0x00, carry_out=1, overflow=0; done exactly 5 edges after start; busy high for 4 cycles.
- Add overflow: a=0x7F, b=0x01 -> s=0x80, carry_out=0, overflow=1. Then a=0x10, b=0x20, cin=1 -> s=0x31, carry_out=0, overflow=0.
- Subtract:
  - a=0x05, b=0x07, sub=1 -> s=0xFE, carry_out=0, overflow=0.
  - a=0x80, b=0x01, sub=1 -> s=0x7F, carry_out=1, overflow=1.
- Handshake: start re-pulsed during RUN with a=0x55 -> ignored; result is from the first operands; exactly one done pulse. Operand change after capture does not affect s.
- Reset mid-op: assert reset low in the 2nd RUN cycle -> s=0, busy=0, done never pulses; a new start after release completes normally.
- Exhaustive and parameter sweep:
  - All 65536 (a,b) pairs in both modes for N=8 W=2, compared against a golden a±b model; zero mismatches.
  - Repeat the spot checks at N=16 W=4 (done after 5 edges) and at N=8 W=1 (done after 9 edges).
